instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Front end of the core. Generates the program counter and issues read requests to instruction memory. Buffers the returned words in a small in-order queue and presents each one with its PC to the decode/control stage. Handles control-flow redirects from the branch path by flushing buffered words and discarding stale in-flight responses.

Parameters:
XLEN, 32, address and instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction queue entries; also the cap on queued plus outstanding requests (power of 2, ≥2)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (≤ FIFO_DEPTH)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  read data valid; in order, one per accepted request, latency ≥1 cycle
imem_rsp_data  in  XLEN  instruction word
redirect_valid  in  1  branch/jump taken; single-cycle pulse
redirect_pc  in  XLEN  new fetch target
instr_valid  out  1  instr_o / instr_pc_o valid to decode
instr_ready  in  1  decode consumes the word this cycle
instr_o  out  XLEN  instruction word
instr_pc_o  out  XLEN  PC of instr_o

Behaviour:
- Reset (rst_n=0, async): imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_o=0, instr_pc_o=0. Internal state: pc=RESET_PC, queue empty, outstanding=0, discard=0, state=IDLE.
- States: IDLE, RUN, FLUSH.
  - IDLE: lasts exactly one cycle after reset release, then moves to RUN. This guarantees the first request goes out on the second rising edge after deassertion.
  - RUN: imem_req_valid=1 whenever (queue count + outstanding) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
  - FLUSH: imem_req_valid=0 while discard>0; moves to RUN in the cycle after discard reaches 0.
- Request handshake: transfer occurs when imem_req_valid and imem_req_ready are both 1. Once asserted, imem_req_valid and imem_req_addr hold stable until the transfer, except on redirect. On transfer: pc += 4 (wraps modulo 2^32), outstanding += 1, and the current pc is pushed to an internal PC tag queue.
- Response: an imem_rsp_valid with discard=0 enqueues {data, tag PC}. Space is always guaranteed by the issue rule; overflow is an assertion failure. Each response decrements outstanding.
- Output: instr_valid = queue not empty; instr_o/instr_pc_o = queue head, combinational from the registered queue. Pop when instr_valid and instr_ready are both 1. A response may enqueue and the head may pop in the same cycle; occupancy is then unchanged. Throughput: 1 instruction/cycle with a 1-cycle-latency memory and FIFO_DEPTH=2.
- Redirect (highest priority):
  - pc ← {redirect_pc[XLEN-1:2], 2'b00} (low bits forced to zero).
  - Queue and tag queue cleared.
  - discard ← outstanding after this cycle's request and response events. A request accepted in the same cycle is counted as stale; a response arriving in the same cycle is dropped.
  - If discard>0, go to FLUSH, otherwise stay in RUN.
  - A pop handshaking in the redirect cycle completes normally.
  - instr_valid=0 in the following cycle.
- FLUSH: each imem_rsp_valid decrements discard and outstanding and is never enqueued. A redirect received during FLUSH updates pc only; discard is unaffected.
- A redirect during IDLE is applied to pc; the state still advances to RUN.
- instr_ready with instr_valid=0 has no effect.

Decomposition:
- Package fetch_pkg holds:
  - XLEN and the RESET_PC default
  - the state enum {IDLE, RUN, FLUSH}
  - the NOP constant 32'h0000_0013, for bench use
  - the queue-entry struct {pc, instr}
- Sub-module fetch_fifo: synchronous FIFO with depth parameter, push, pop, flush, full, empty and count. Flush has priority over push. Used for the instruction queue.

Test Plan:
1. Reset release with imem_req_ready=1, 1-cycle memory returning 32'h0000_0013, 32'h00A00093, … → requests at addresses 0, 4, 8 on consecutive cycles; instr_valid rises on the third cycle after release with instr_pc_o=0 and instr_o=32'h0000_0013; then one instruction per cycle.
2. instr_ready=0 for 5 cycles → at most 2 requests beyond the consumed ones; imem_req_valid=0 when full; no word lost or reordered after instr_ready=1.
3. Redirect to 32'h0000_0103 with 2 outstanding, 3-cycle memory latency → both stale responses dropped; next request address 32'h0000_0100; first instr_pc_o=32'h100.
4. Redirect in the same cycle as a request transfer and a response → that response dropped, the accepted request discarded later, fetch resumes at the target.
5. imem_req_ready held low for 4 cycles → imem_req_addr stable for the whole stall.
6. rst_n asserted mid-stream with 2 outstanding → all outputs return to reset values immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC. The memory model is reset too.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO; flush wins over push, push allowed when full if a pop frees a slot.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

    // Pointer, occupancy and storage update.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // A push that cannot be stored means the issue logic broke its own space guarantee.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(push && full && !do_pop));
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC generation, memory request issue, in-order instruction queue, redirect flush.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic              pop_c;
    logic [OCC_W-1:0]  occ_c;
    logic              req_valid_c;
    logic              req_fire_c;
    logic              rsp_keep_c;

    fetch_entry_t      q_push_data;
    fetch_entry_t      q_head;
    logic              q_full, q_empty;
    logic [CNT_W-1:0]  q_count;

    logic [XLEN-1:0]   tag_head;
    logic              tag_full, tag_empty;
    logic [CNT_W-1:0]  tag_count;

    // Handshakes. The request valid counts a pop happening this cycle as freed space,
    // which keeps one request per cycle flowing against a full-rate decoder; once raised
    // it cannot drop without a transfer because occupancy only falls until the next transfer.
    always_comb begin
        pop_c       = !q_empty && instr_ready;
        occ_c       = OCC_W'(q_count) + OCC_W'(out_q) - OCC_W'(pop_c);
        req_valid_c = (state_q == RUN) && (occ_c < OCC_W'(FIFO_DEPTH))
                      && (out_q < CNT_W'(MAX_OUTSTANDING));
        req_fire_c  = req_valid_c && imem_req_ready;
        rsp_keep_c  = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    end

    // Next-state: PC, outstanding count, discard count and FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        out_d     = out_q + CNT_W'(req_fire_c) - CNT_W'(imem_rsp_valid);
        discard_d = discard_q;
        if (req_fire_c) begin
            pc_d = pc_q + XLEN'(4);
        end
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    discard_d = out_d;
                    if (out_d != '0) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (imem_rsp_valid) begin
                    discard_d = discard_q - CNT_W'(1);
                end
                if (discard_q == '0) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            out_q     <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            out_q     <= out_d;
            discard_q <= discard_d;
        end
    end

    // Queue entry formed from the response word and the PC tag of its request.
    always_comb begin
        q_push_data       = '0;
        q_push_data.pc    = tag_head;
        q_push_data.instr = imem_rsp_data;
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep_c),
        .push_data (q_push_data),
        .pop       (pop_c),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire_c),
        .push_data (pc_q),
        .pop       (rsp_keep_c),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assign imem_req_valid = req_valid_c;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = !q_empty;
    assign instr_o        = q_empty ? '0 : q_head.instr;
    assign instr_pc_o     = q_empty ? '0 : q_head.pc;

    logic unused_ok;
    assign unused_ok = ^{q_full, tag_full, tag_empty, tag_count, redirect_pc[1:0]};

endmodule
